// File: rtl/poly_note_player_if.sv
// Control/status bundle for poly_note_player.
//   master : song reader / chord sequencer / codec side (drives requests)
//   slave  : poly_note_player (drives load status, voice flags, mix)
interface poly_note_player_if #(
  parameter int NUM_VOICES   = 3,
  parameter int NOTE_WIDTH   = 6,
  parameter int DUR_WIDTH    = 6,
  parameter int SAMPLE_WIDTH = 16
);
  localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int MIX_WIDTH = SAMPLE_WIDTH + ((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1);

  logic                    play_enable;
  logic                    load_new_note;
  logic [NOTE_WIDTH-1:0]   note_to_load;
  logic [DUR_WIDTH-1:0]    duration;
  logic                    beat;
  logic                    generate_next_sample;
  logic                    load_accepted;
  logic [VOICE_W-1:0]      load_voice;
  logic                    voice_stolen;
  logic [NUM_VOICES-1:0]   voice_active;
  logic [NUM_VOICES-1:0]   voice_done;
  logic [MIX_WIDTH-1:0]    sample_out;
  logic                    sample_ready;

  modport master (
    output play_enable, load_new_note, note_to_load, duration, beat, generate_next_sample,
    input  load_accepted, load_voice, voice_stolen, voice_active, voice_done,
           sample_out, sample_ready
  );

  modport slave (
    input  play_enable, load_new_note, note_to_load, duration, beat, generate_next_sample,
    output load_accepted, load_voice, voice_stolen, voice_active, voice_done,
           sample_out, sample_ready
  );
endinterface

// File: rtl/poly_note_player.sv
// Polyphonic note player: NUM_VOICES voices, each a note register, a
// frequency_rom and a sine_reader, plus a beat-driven duration counter.
// New notes go to the lowest idle voice, otherwise the voice closest to
// expiry is stolen. One registered full-precision signed mix is produced
// per codec sample request.
// Ports: clk, reset (async, active high), bus (poly_note_player_if.slave).

// Note -> phase step, one cycle of latency. Linear pitch map: each note
// unit advances the 64-entry sine table by one entry per sample.
module frequency_rom #(
  parameter int NOTE_WIDTH = 6,
  parameter int PHASE_W    = NOTE_WIDTH + 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NOTE_WIDTH-1:0] note,
  output logic [PHASE_W-1:0]    step
);
  always_ff @(posedge clk or posedge reset)
    if (reset) step <= '0;
    else       step <= {note, 6'b0};
endmodule

// Phase accumulator + 64-point sine table (16-bit full scale).
// generate_next advances the phase; the sample for the new phase is
// registered one cycle later together with its sample_ready pulse.
module sine_reader #(
  parameter int PHASE_W      = 12,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           generate_next,
  input  logic [PHASE_W-1:0]             step,
  output logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic                           sample_ready
);
  logic [PHASE_W-1:0] phase;
  logic [1:0]         vld_pipe;

  function automatic logic [15:0] quarter(input logic [4:0] k);
    case (k)
      5'd0:  quarter = 16'd0;     5'd1:  quarter = 16'd3212;
      5'd2:  quarter = 16'd6393;  5'd3:  quarter = 16'd9512;
      5'd4:  quarter = 16'd12539; 5'd5:  quarter = 16'd15446;
      5'd6:  quarter = 16'd18204; 5'd7:  quarter = 16'd20787;
      5'd8:  quarter = 16'd23170; 5'd9:  quarter = 16'd25329;
      5'd10: quarter = 16'd27245; 5'd11: quarter = 16'd28898;
      5'd12: quarter = 16'd30273; 5'd13: quarter = 16'd31356;
      5'd14: quarter = 16'd32137; 5'd15: quarter = 16'd32609;
      5'd16: quarter = 16'd32767;
      default: quarter = 16'd0;
    endcase
  endfunction

  // Quarter-wave symmetry: mirror the index in odd quadrants, negate the
  // second half of the period.
  function automatic logic signed [15:0] sine_lut(input logic [5:0] idx);
    logic [4:0] k;
    k = {1'b0, idx[3:0]};
    case (idx[5:4])
      2'd0:    sine_lut =  $signed(quarter(k));
      2'd1:    sine_lut =  $signed(quarter(5'd16 - k));
      2'd2:    sine_lut = -$signed(quarter(k));
      default: sine_lut = -$signed(quarter(5'd16 - k));
    endcase
  endfunction

  assign vld_pipe[0] = generate_next;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase        <= '0;
      vld_pipe[1]  <= 1'b0;
      sample       <= '0;
      sample_ready <= 1'b0;
    end else begin
      vld_pipe[1]  <= vld_pipe[0];
      sample_ready <= vld_pipe[1];
      if (vld_pipe[0]) phase  <= phase + step;
      if (vld_pipe[1]) sample <= SAMPLE_WIDTH'(sine_lut(phase[PHASE_W-1 -: 6]));
    end
endmodule

module poly_note_player #(
  parameter int NUM_VOICES   = 3,
  parameter int NOTE_WIDTH   = 6,
  parameter int DUR_WIDTH    = 6,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  poly_note_player_if.slave  bus
);
  localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int MIX_WIDTH = SAMPLE_WIDTH + ((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1);
  localparam int PHASE_W   = NOTE_WIDTH + 6;

  logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] note_q;
  logic [NUM_VOICES-1:0][DUR_WIDTH-1:0]  count_q;
  logic [NUM_VOICES-1:0][PHASE_W-1:0]    step;
  logic [NUM_VOICES-1:0]                 active_q, done_q, rdy_q, smp_rdy, load_hit;
  logic signed [SAMPLE_WIDTH-1:0]        smp [NUM_VOICES];

  logic                        take, steal, found_idle, ticking, gen_next;
  logic [VOICE_W-1:0]          tgt;
  logic [DUR_WIDTH-1:0]        min_cnt;
  logic                        load_acc_q, stolen_q, smp_rdy_q;
  logic [VOICE_W-1:0]          load_voice_q;
  logic signed [MIX_WIDTH-1:0] mix, sample_q;

  assign take     = bus.load_new_note && (bus.duration != '0);
  assign ticking  = bus.beat && bus.play_enable;
  assign gen_next = bus.play_enable && bus.generate_next_sample;

  // Target selection: lowest idle voice, else smallest remaining count
  // (strict compare keeps ties on the lowest index).
  always_comb begin
    tgt        = '0;
    found_idle = 1'b0;
    min_cnt    = count_q[0];
    for (int i = 0; i < NUM_VOICES; i++)
      if (!active_q[i] && !found_idle) begin
        tgt        = VOICE_W'(i);
        found_idle = 1'b1;
      end
    if (!found_idle)
      for (int i = 1; i < NUM_VOICES; i++)
        if (count_q[i] < min_cnt) begin
          tgt     = VOICE_W'(i);
          min_cnt = count_q[i];
        end
    steal = !found_idle;
    for (int i = 0; i < NUM_VOICES; i++)
      load_hit[i] = take && (tgt == VOICE_W'(i));
  end

  // Voice state. A load on a voice overrides a same-cycle beat, and a
  // stolen voice never reports done because it never reaches count 0.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      note_q       <= '0;
      count_q      <= '0;
      active_q     <= '0;
      done_q       <= '0;
      load_acc_q   <= 1'b0;
      stolen_q     <= 1'b0;
      load_voice_q <= '0;
    end else begin
      load_acc_q   <= take;
      stolen_q     <= take && steal;
      load_voice_q <= take ? tgt : '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        done_q[i] <= 1'b0;
        if (load_hit[i]) begin
          note_q[i]   <= bus.note_to_load;
          count_q[i]  <= bus.duration;
          active_q[i] <= 1'b1;
        end else if (ticking && active_q[i]) begin
          count_q[i] <= count_q[i] - DUR_WIDTH'(1);
          if (count_q[i] == DUR_WIDTH'(1)) begin
            active_q[i] <= 1'b0;
            done_q[i]   <= 1'b1;
          end
        end
      end
    end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    frequency_rom #(.NOTE_WIDTH(NOTE_WIDTH), .PHASE_W(PHASE_W)) u_rom (
      .clk (clk), .reset (reset), .note (note_q[g]), .step (step[g])
    );
    sine_reader #(.PHASE_W(PHASE_W), .SAMPLE_WIDTH(SAMPLE_WIDTH)) u_sine (
      .clk (clk), .reset (reset), .generate_next (gen_next), .step (step[g]),
      .sample (smp[g]), .sample_ready (smp_rdy[g])
    );
  end

  // Silent voices (idle or rest) contribute nothing; headroom bits make
  // the sum exact.
  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (active_q[i] && (note_q[i] != '0))
        mix = mix + MIX_WIDTH'(smp[i]);
  end

  // Sticky per-voice ready set. A new request wipes it, so a request that
  // arrives mid-collection abandons the earlier one.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rdy_q     <= '0;
      sample_q  <= '0;
      smp_rdy_q <= 1'b0;
    end else begin
      smp_rdy_q <= 1'b0;
      if (bus.generate_next_sample) begin
        rdy_q <= '0;
      end else if (&rdy_q) begin
        sample_q  <= mix;
        smp_rdy_q <= 1'b1;
        rdy_q     <= '0;
      end else begin
        rdy_q <= rdy_q | smp_rdy;
      end
    end

  assign bus.load_accepted = load_acc_q;
  assign bus.load_voice    = load_voice_q;
  assign bus.voice_stolen  = stolen_q;
  assign bus.voice_active  = active_q;
  assign bus.voice_done    = done_q;
  assign bus.sample_out    = sample_q;
  assign bus.sample_ready  = smp_rdy_q;
endmodule

// File: tb/tb_poly_note_player.sv
// Scoreboard bench for poly_note_player (3 voices, default widths).
// Stimulus updates a note-level model and queues expected load results,
// done pulses and mix values; a negedge monitor pops and compares them.
module tb_poly_note_player;
  localparam int NV = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  poly_note_player_if #(.NUM_VOICES(NV)) bif ();
  poly_note_player #(.NUM_VOICES(NV)) dut (.clk(clk), .reset(rst), .bus(bif));

  typedef struct { int voice; bit stolen; } ld_t;
  ld_t ld_q[$];
  int  smp_q[$];
  int  done_q[$];

  int  m_note[NV], m_cnt[NV], m_idx[NV];
  bit  m_act[NV];
  logic [NV-1:0] exp_active = '0;
  bit  mon_en = 0;
  int  checks = 0, errors = 0;

  function automatic int sine_ref(int idx);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979 * idx / 64.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_note[v] = 0; m_cnt[v] = 0; m_idx[v] = 0; m_act[v] = 0;
    end
    ld_q.delete(); smp_q.delete(); done_q.delete();
    exp_active = '0;
  endtask

  // Apply one cycle of inputs; the model advances as of the coming edge.
  task automatic step(bit ld, int note, int dur, bit bt, bit gn, bit pe);
    int tgt, mask, sum;
    int idle[$];
    bif.load_new_note = ld; bif.note_to_load = 6'(note); bif.duration = 6'(dur);
    bif.beat = bt; bif.generate_next_sample = gn; bif.play_enable = pe;
    tgt = -1;
    if (ld && dur != 0) begin
      bit stl;
      idle = {};
      for (int v = 0; v < NV; v++) if (!m_act[v]) idle.push_back(v);
      stl = (idle.size() == 0);
      if (!stl) tgt = idle[0];
      else begin
        tgt = 0;
        for (int v = 1; v < NV; v++) if (m_cnt[v] < m_cnt[tgt]) tgt = v;
      end
      ld_q.push_back('{tgt, stl});
      m_note[tgt] = note; m_cnt[tgt] = dur; m_act[tgt] = 1;
    end
    if (bt && pe) begin
      mask = 0;
      for (int v = 0; v < NV; v++)
        if (m_act[v] && v != tgt) begin
          m_cnt[v]--;
          if (m_cnt[v] == 0) begin m_act[v] = 0; mask |= (1 << v); end
        end
      if (mask != 0) done_q.push_back(mask);
    end
    if (gn && pe) begin
      sum = 0;
      for (int v = 0; v < NV; v++) begin
        m_idx[v] = (m_idx[v] + m_note[v]) % 64;
        if (m_act[v] && m_note[v] != 0) sum += sine_ref(m_idx[v]);
      end
      smp_q.push_back(sum);
    end
    @(posedge clk); #1;
    for (int v = 0; v < NV; v++) exp_active[v] = m_act[v];
    bif.load_new_note = 0; bif.beat = 0; bif.generate_next_sample = 0; bif.play_enable = 1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic load(int note, int dur); step(1, note, dur, 0, 0, 1); idle(1); endtask
  task automatic request();               step(0, 0, 0, 0, 1, 1); idle(4); endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("reset_sample_out", int'($signed(bif.sample_out)), 0);
    chk("reset_voice_active", int'(bif.voice_active), 0);
    chk("reset_load_accepted", int'(bif.load_accepted), 0);
    model_clear();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("voice_active", int'(bif.voice_active), int'(exp_active));
      if (bif.voice_stolen && !bif.load_accepted) chk("stolen_without_accept", 1, 0);
      if (bif.load_accepted) begin
        if (ld_q.size() == 0) chk("unexpected_load_accepted", 1, 0);
        else begin
          ld_t e;
          e = ld_q.pop_front();
          chk("load_voice", int'(bif.load_voice), e.voice);
          chk("voice_stolen", int'(bif.voice_stolen), int'(e.stolen));
        end
      end
      if (bif.voice_done != '0) begin
        if (done_q.size() == 0) chk("unexpected_voice_done", int'(bif.voice_done), 0);
        else chk("voice_done", int'(bif.voice_done), done_q.pop_front());
      end
      if (bif.sample_ready) begin
        if (smp_q.size() == 0) chk("unexpected_sample_ready", 1, 0);
        else chk("sample_out", int'($signed(bif.sample_out)), smp_q.pop_front());
      end
    end
  end

  initial begin
    bif.play_enable = 1; bif.load_new_note = 0; bif.note_to_load = 0;
    bif.duration = 0; bif.beat = 0; bif.generate_next_sample = 0;
    model_clear();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1;

    // Full-scale mix: fresh phases, three note-16 voices hit the +32767 peak.
    load(16, 40); load(16, 40); load(16, 40);
    request();
    chk("mix_full_scale", int'($signed(bif.sample_out)), 98301);

    // Reset mid-note with a nonzero mix held.
    do_reset();
    load(5, 9); request();
    do_reset();

    // Three loads fill the voices in order.
    load(10, 4); load(20, 4); load(30, 4);
    chk("all_active", int'(bif.voice_active), 7);
    request();

    // Counts 3/1/2 then a fourth load steals voice 1, no done pulse.
    do_reset();
    load(10, 4); load(20, 2); load(30, 3);
    step(0, 0, 0, 1, 0, 1);
    load(40, 5);
    idle(2);

    // Duration-2 expiry, duration-0 load ignored.
    do_reset();
    load(12, 2);
    step(0, 0, 0, 1, 0, 1); step(0, 0, 0, 1, 0, 1);
    idle(2);
    chk("expired_inactive", int'(bif.voice_active), 0);
    step(1, 9, 0, 0, 0, 1); idle(2);

    // Load and beat in the same cycle, then three beats to done.
    step(1, 7, 3, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1); step(0, 0, 0, 1, 0, 1); step(0, 0, 0, 1, 0, 1);
    idle(2);

    // Rest voice plus sounding voices; play_enable low freezes things.
    load(0, 6); load(11, 6); load(23, 6);
    request();
    step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 1, 0); idle(4);
    request();

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        step(1, $urandom_range(0, 63), $urandom_range(0, 6), $urandom_range(0, 3) == 0, 0, 1);
        idle(1);
      end else if (r <= 6) step(0, 0, 0, 1, 0, $urandom_range(0, 3) != 0);
      else if (r <= 8) begin
        step(0, 0, 0, 0, 1, $urandom_range(0, 3) != 0);
        idle(4);
      end else idle(1);
    end

    idle(6);
    chk("pending_loads", ld_q.size(), 0);
    chk("pending_samples", smp_q.size(), 0);
    chk("pending_done", done_q.size(), 0);
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/poly_note_player.md
Name: poly_note_player

Overview:
- Parametrised polyphonic successor to the three-voice note player.
- Holds NUM_VOICES independent voices, each built from a note register, a frequency_rom and a sine_reader.
- Each voice has a beat-driven duration counter. New notes go to the lowest-index idle voice; when all voices are busy, the voice with the least remaining time is stolen.
- Sits between the song reader / chord sequencer and the codec-side adder/effects chain. It emits one registered, width-extended signed mix per codec sample request.

Parameters:
- NUM_VOICES, 3: number of simultaneous voices, 1..8.
- NOTE_WIDTH, 6: note index width; note 0 is a rest.
- DUR_WIDTH, 6: duration width, in beats.
- SAMPLE_WIDTH, 16: signed per-voice sample width from sine_reader.
- MIX_WIDTH (localparam) = SAMPLE_WIDTH + $clog2(NUM_VOICES), minimum SAMPLE_WIDTH + 1. The default configuration gives 18.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- play_enable  in  1  when low, counters freeze and no samples are requested.
- load_new_note  in  1  one-cycle request to start a note.
- note_to_load  in  NOTE_WIDTH  note index.
- duration  in  DUR_WIDTH  note length in beats.
- beat  in  1  one-cycle 1/48 s tick.
- generate_next_sample  in  1  codec sample request pulse.
- load_accepted  out  1  pulse one cycle after a load is taken.
- load_voice  out  $clog2(NUM_VOICES) (min 1)  voice that took the load; valid while load_accepted is high.
- voice_stolen  out  1  pulse with load_accepted when a busy voice was overwritten.
- voice_active  out  NUM_VOICES  per-voice busy flags.
- voice_done  out  NUM_VOICES  per-voice one-cycle pulse when a note expires.
- sample_out  out  MIX_WIDTH  signed mix, registered.
- sample_ready  out  1  one-cycle pulse when sample_out is updated.

Behaviour:
- Reset (async): all counters and note registers become 0 and voice_active becomes 0. load_accepted, voice_stolen, voice_done, sample_ready, load_voice and sample_out all become 0. The mid-note reset also aborts pending sample collection.
- Load rules:
  - A load with duration == 0 is ignored: no acceptance, no state change.
  - Otherwise the target is the lowest-index voice with voice_active == 0.
  - If no voice is idle, the target is the voice with the smallest count (ties go to the lowest index), and voice_stolen is raised.
  - Target voice: note register <= note_to_load, count <= duration, active <= 1.
  - load_accepted and load_voice are registered, so they appear the cycle after the request.
  - Loads are accepted regardless of play_enable.
- Counters:
  - On a beat with play_enable high, every active voice not being loaded that cycle decrements.
  - A voice whose count is 1 on such a beat goes to count 0 and active 0. Its voice_done bit pulses the following cycle.
  - Load and beat on the same voice in the same cycle: the load wins, with no decrement and no voice_done.
  - A stolen voice does not raise voice_done.
- Voice datapath:
  - frequency_rom gives one cycle of latency from the note register.
  - sine_reader.generate_next = play_enable & generate_next_sample.
  - Phase is not reset on load.
- Mixer:
  - Each voice's contribution is its sample, sign-extended to MIX_WIDTH, when that voice is active and its note is not 0. Otherwise it contributes 0.
  - A sticky ready bit is set per voice on its sine_reader sample_ready. The set is cleared on generate_next_sample.
  - When all NUM_VOICES ready bits are set, sample_out <= sum of contributions. sample_ready pulses on the next cycle and the bits clear.
  - The sum is full-precision, so no overflow or saturation is possible.
- A generate_next_sample arriving before collection completes restarts collection; no sample_ready is emitted for the abandoned request.
- play_enable low: beats are ignored, no sample requests reach the voices, and sample_out holds its value.

Test Plan:
- Reset mid-note, then release → sample_out = 0 and voice_active = 0 with no clock edge required; the next load goes to voice 0.
- Three loads (notes 10/20/30, durations 4/4/4), N=3 → load_voice = 0, 1, 2, each with load_accepted one cycle later; voice_active = 3'b111.
- Fourth load while all busy, with counts 3/1/2 → load_voice = 1 and voice_stolen = 1; no voice_done[1].
- Load duration 2 then 2 beats → voice_done[0] pulses once, in the cycle after the second beat; voice_active[0] = 0. A duration-0 load produces no load_accepted.
- Load and beat in the same cycle on an idle voice with duration 3 → count = 3, then 3 more beats to done.
- Force all three voice samples to +32767, then request a sample → sample_out = 98301 (18-bit) with one sample_ready pulse. Rest voices (note 0) contribute 0.
